// File: rtl/lib_arbiter_pkg.sv
// Shared definitions for the pixel-array AER readout: default field widths,
// the packed AER word layout and the word-type codes.
package lib_arbiter_pkg;

  localparam int ROW_ADD  = 3;
  localparam int COL_ADD  = 3;
  localparam int TS_WIDTH = 16;
  localparam int AER_W    = 1 + TS_WIDTH + ROW_ADD + COL_ADD + 1;

  localparam logic AER_TYPE_EVENT = 1'b0;
  localparam logic AER_TYPE_WRAP  = 1'b1;

  typedef struct packed {
    logic                word_type;
    logic [TS_WIDTH-1:0] ts;
    logic [ROW_ADD-1:0]  y;
    logic [COL_ADD-1:0]  x;
    logic                pol;
  } aer_word_t;

endpackage

// File: rtl/aer_event_packer_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is visible on
// data_o whenever the FIFO is non-empty and zero otherwise.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Push/pop qualification; a pop in the same cycle frees a slot for a push.
  always_comb begin
    full_s    = (count_r == DEPTH_C);
    empty_s   = (count_r == {(PTR_W + 1){1'b0}});
    do_pop_s  = pop_i && !empty_s;
    do_push_s = push_i && (!full_s || do_pop_s);
    if (empty_s) begin
      data_o = {WIDTH{1'b0}};
    end else begin
      data_o = mem_r[rd_ptr_r];
    end
  end

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Pointers and occupancy count; power-of-two depth gives natural wrap.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign count_o = count_r;

endmodule

// File: rtl/aer_event_packer.sv
// Packs granted pixel events into timestamped AER words, inserts a marker on
// every timestamp wrap, and queues the words for a valid/ready readout.
module aer_event_packer #(
  parameter int ROW_ADD    = lib_arbiter_pkg::ROW_ADD,
  parameter int COL_ADD    = lib_arbiter_pkg::COL_ADD,
  parameter int TS_WIDTH   = lib_arbiter_pkg::TS_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   enable_i,
  input  logic                                   event_valid_i,
  input  logic [COL_ADD-1:0]                     x_add_i,
  input  logic [ROW_ADD-1:0]                     y_add_i,
  input  logic                                   polarity_i,
  input  logic                                   ready_i,
  output logic [TS_WIDTH+ROW_ADD+COL_ADD+1:0]    event_o,
  output logic                                   valid_o,
  output logic                                   fifo_full_o,
  output logic [DROP_W-1:0]                      drop_cnt_o
);

  import lib_arbiter_pkg::*;

  localparam int W     = 1 + TS_WIDTH + ROW_ADD + COL_ADD + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C = FIFO_DEPTH[CNT_W-1:0];
  localparam logic [TS_WIDTH-1:0] TS_MAX  = {TS_WIDTH{1'b1}};
  localparam logic [TS_WIDTH-1:0] TS_ONE  = TS_WIDTH'(1'b1);

  logic [TS_WIDTH-1:0] ts_r;
  logic                wrap_pend_r;
  logic [DROP_W-1:0]   drop_cnt_r;
  logic                marker_due_s;
  logic                wr_req_s;
  logic                pop_s;
  logic                accept_s;
  logic [W-1:0]        wr_word_s;
  logic [W-1:0]        head_s;
  logic [1:0]          drop_inc_s;
  logic [DROP_W:0]     drop_sum_s;
  logic                full_s;
  logic                empty_s;
  logic [CNT_W-1:0]    count_s;

  // Write-slot arbitration: a pending wrap marker pre-empts any event.
  always_comb begin
    marker_due_s = 1'b0;
    wr_word_s    = {W{1'b0}};
    drop_inc_s   = 2'd0;
    if (enable_i && wrap_pend_r) begin
      marker_due_s = 1'b1;
    end else begin
      marker_due_s = 1'b0;
    end
    wr_req_s = enable_i && (marker_due_s || event_valid_i);
    pop_s    = !empty_s && ready_i;
    accept_s = wr_req_s && (!full_s || pop_s);
    if (marker_due_s) begin
      wr_word_s = {AER_TYPE_WRAP, {(W - 1){1'b0}}};
    end else begin
      wr_word_s = {AER_TYPE_EVENT, ts_r, y_add_i, x_add_i, polarity_i};
    end
    // An event colliding with the marker and a refused write can both occur.
    if (marker_due_s && event_valid_i) begin
      drop_inc_s = drop_inc_s + 2'd1;
    end else begin
      drop_inc_s = drop_inc_s;
    end
    if (wr_req_s && !accept_s) begin
      drop_inc_s = drop_inc_s + 2'd1;
    end else begin
      drop_inc_s = drop_inc_s;
    end
    drop_sum_s = {1'b0, drop_cnt_r} + {{(DROP_W - 1){1'b0}}, drop_inc_s};
  end

  // Free-running timestamp and wrap-pending flag, both frozen while disabled.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ts_r        <= {TS_WIDTH{1'b0}};
      wrap_pend_r <= 1'b0;
    end else if (enable_i) begin
      ts_r <= ts_r + TS_ONE;
      if (ts_r == TS_MAX) begin
        wrap_pend_r <= 1'b1;
      end else if (marker_due_s) begin
        wrap_pend_r <= 1'b0;
      end
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_r <= {DROP_W{1'b0}};
    end else if (drop_sum_s[DROP_W]) begin
      drop_cnt_r <= {DROP_W{1'b1}};
    end else begin
      drop_cnt_r <= drop_sum_s[DROP_W-1:0];
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (accept_s),
    .pop_i   (pop_s),
    .data_i  (wr_word_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  assign event_o     = head_s;
  assign valid_o     = !empty_s;
  assign fifo_full_o = (count_s == DEPTH_C);
  assign drop_cnt_o  = drop_cnt_r;

endmodule
